// File: rtl/md_issue_ctrl_pkg.sv
// Shared types and defaults for the multdiv issue/writeback controller.
// State encoding is a plain logic vector so the constants stay legacy-compatible.
package md_issue_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;

   localparam int unsigned RSTATUS_REG_DEF   = 30;
   localparam int unsigned MULT_EXC_CODE_DEF = 4;
   localparam int unsigned DIV_EXC_CODE_DEF  = 5;

   typedef logic [1:0] md_state_t;

   localparam md_state_t StIdle  = 2'd0;
   localparam md_state_t StIssue = 2'd1;
   localparam md_state_t StWait  = 2'd2;
   localparam md_state_t StWb    = 2'd3;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Upstream, multdiv and writeback signals of md_issue_ctrl.
// slave = controller side, master = surrounding pipeline / multdiv side.
interface md_issue_ctrl_if;
   import md_issue_ctrl_pkg::*;

   logic                 md_valid;
   logic                 md_is_div;
   logic [31:0]          md_opA;
   logic [31:0]          md_opB;
   logic [REG_IDX_W-1:0] md_rd;
   logic                 md_flush;
   logic                 md_ready;
   logic                 md_busy;
   logic                 ctrl_MULT;
   logic                 ctrl_DIV;
   logic [31:0]          md_operandA;
   logic [31:0]          md_operandB;
   logic [31:0]          data_result;
   logic                 data_exception;
   logic                 data_resultRDY;
   logic                 wb_valid;
   logic [REG_IDX_W-1:0] wb_reg;
   logic [31:0]          wb_data;
   logic                 md_timeout;

   modport slave (
      input  md_valid, md_is_div, md_opA, md_opB, md_rd, md_flush,
      input  data_result, data_exception, data_resultRDY,
      output md_ready, md_busy, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
      output wb_valid, wb_reg, wb_data, md_timeout
   );

   modport master (
      output md_valid, md_is_div, md_opA, md_opB, md_rd, md_flush,
      output data_result, data_exception, data_resultRDY,
      input  md_ready, md_busy, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
      input  wb_valid, wb_reg, wb_data, md_timeout
   );

endinterface

// File: rtl/md_wait_counter.sv
// Saturating up-counter with synchronous clear; used as the multdiv watchdog.
module md_wait_counter #(
   parameter int unsigned Width = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/writeback controller for the multdiv unit: one op in flight, stall until done.
// Optional watchdog on the WAIT state is enabled with `define MD_WATCHDOG_EN.
module md_issue_ctrl
   import md_issue_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT      = 64,
   parameter int unsigned RSTATUS_REG   = RSTATUS_REG_DEF,
   parameter int unsigned MULT_EXC_CODE = MULT_EXC_CODE_DEF,
   parameter int unsigned DIV_EXC_CODE  = DIV_EXC_CODE_DEF
) (
   input  logic           clock,
   input  logic           reset,
   md_issue_ctrl_if.slave bus
);

   md_state_t            state_d, state_q;
   logic [31:0]          opa_d, opa_q;
   logic [31:0]          opb_d, opb_q;
   logic                 is_div_d, is_div_q;
   logic [REG_IDX_W-1:0] rd_d, rd_q;
   logic [31:0]          result_d, result_q;
   logic                 exc_d, exc_q;
   logic                 timeout_d, timeout_q;
   logic                 wd_expire;

`ifdef MD_WATCHDOG_EN
   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
   logic [CntW-1:0] wait_cnt;

   // Counts 1 in the first WAIT cycle, so expiry lands on WAIT cycle MAX_WAIT.
   md_wait_counter #(
      .Width (CntW)
   ) u_wait_cnt (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (state_q == StIdle),
      .en_i  ((state_q == StIssue) || (state_q == StWait)),
      .cnt_o (wait_cnt)
   );

   assign wd_expire      = (state_q == StWait) && (wait_cnt == CntW'(MAX_WAIT));
   assign bus.md_timeout = (state_q == StWb) && timeout_q;
`else
   assign wd_expire      = 1'b0;
   assign bus.md_timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      rd_d      = rd_q;
      result_d  = result_q;
      exc_d     = exc_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (bus.md_valid && !bus.md_flush) begin
               opa_d     = bus.md_opA;
               opb_d     = bus.md_opB;
               is_div_d  = bus.md_is_div;
               rd_d      = bus.md_rd;
               timeout_d = 1'b0;
               state_d   = StIssue;
            end
         end
         // RDY here belongs to an earlier, flushed op.
         StIssue: state_d = bus.md_flush ? StIdle : StWait;
         StWait: begin
            if (bus.md_flush) begin
               state_d = StIdle;
            end else if (bus.data_resultRDY) begin
               result_d  = bus.data_result;
               exc_d     = bus.data_exception;
               timeout_d = 1'b0;
               state_d   = StWb;
            end else if (wd_expire) begin
               exc_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = StWb;
            end
         end
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         opa_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         rd_q      <= '0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         rd_q      <= rd_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.md_ready    = (state_q == StIdle);
   assign bus.md_busy     = (state_q != StIdle);
   assign bus.ctrl_MULT   = (state_q == StIssue) && !is_div_q;
   assign bus.ctrl_DIV    = (state_q == StIssue) && is_div_q;
   assign bus.md_operandA = opa_q;
   assign bus.md_operandB = opb_q;

   always_comb begin
      bus.wb_valid = 1'b0;
      bus.wb_reg   = '0;
      bus.wb_data  = '0;
      if (state_q == StWb) begin
         if (exc_q) begin
            bus.wb_valid = 1'b1;
            bus.wb_reg   = REG_IDX_W'(RSTATUS_REG);
            bus.wb_data  = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
         end else begin
            bus.wb_valid = (rd_q != '0);
            bus.wb_reg   = rd_q;
            bus.wb_data  = result_q;
         end
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; watchdog case runs only with MD_WATCHDOG_EN.
module tb_md_issue_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   md_issue_ctrl_if bus ();

   md_issue_ctrl #(
      .MAX_WAIT (8)
   ) u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".ready"}, 32'(bus.md_ready), 32'd1);
      check({tag, ".busy"}, 32'(bus.md_busy), 32'd0);
      check({tag, ".wbv"}, 32'(bus.wb_valid), 32'd0);
   endtask

   task automatic check_wb(input string tag, input logic v, input logic [4:0] r,
                           input logic [31:0] d);
      check({tag, ".wbv"}, 32'(bus.wb_valid), 32'(v));
      check({tag, ".wbreg"}, 32'(bus.wb_reg), 32'(r));
      check({tag, ".wbdata"}, bus.wb_data, d);
      check({tag, ".busy"}, 32'(bus.md_busy), 32'd1);
      check({tag, ".tmo"}, 32'(bus.md_timeout), 32'd0);
   endtask

   // Leaves the DUT in WB after accept + n_wait + 3 cycles.
   task automatic run_op(input string tag, input logic div, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int n_wait,
                         input logic [31:0] res, input logic exc);
      bus.md_valid  = 1'b1;
      bus.md_is_div = div;
      bus.md_opA    = a;
      bus.md_opB    = b;
      bus.md_rd     = rd;
      tick();
      bus.md_valid  = 1'b0;
      bus.md_opA    = 32'hFFFF_FFFF;
      check({tag, ".mult"}, 32'(bus.ctrl_MULT), 32'(!div));
      check({tag, ".div"}, 32'(bus.ctrl_DIV), 32'(div));
      tick();
      check({tag, ".pulse"}, 32'(bus.ctrl_MULT | bus.ctrl_DIV), 32'd0);
      for (int i = 0; i < n_wait; i++) tick();
      check({tag, ".prewb"}, 32'(bus.wb_valid), 32'd0);
      check({tag, ".opA"}, bus.md_operandA, a);
      bus.data_resultRDY = 1'b1;
      bus.data_result    = res;
      bus.data_exception = exc;
      tick();
      bus.data_resultRDY = 1'b0;
      bus.data_exception = 1'b0;
      check({tag, ".opB"}, bus.md_operandB, b);
   endtask

   initial begin
      bus.md_valid       = 1'b0;
      bus.md_is_div      = 1'b0;
      bus.md_opA         = '0;
      bus.md_opB         = '0;
      bus.md_rd          = '0;
      bus.md_flush       = 1'b0;
      bus.data_result    = '0;
      bus.data_exception = 1'b0;
      bus.data_resultRDY = 1'b0;
      tick();
      tick();
      check_idle("rst");
      check("rst.ctrl", 32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
      check("rst.opA", bus.md_operandA, 32'd0);
      check("rst.tmo", 32'(bus.md_timeout), 32'd0);
      rst = 1'b0;
      tick();

      run_op("mult", 1'b0, 32'd7, 32'd6, 5'd3, 5, 32'd42, 1'b0);
      check_wb("mult", 1'b1, 5'd3, 32'd42);
      tick();
      check_idle("mult.post");

      run_op("div0", 1'b1, 32'd100, 32'd0, 5'd9, 2, 32'hDEAD, 1'b1);
      check_wb("div0", 1'b1, 5'd30, 32'd5);
      tick();

      run_op("movf", 1'b0, 32'h8000_0000, 32'd4, 5'd0, 0, 32'h1234, 1'b1);
      check_wb("movf", 1'b1, 5'd30, 32'd4);
      tick();

      run_op("mrd0", 1'b0, 32'd3, 32'd5, 5'd0, 1, 32'd15, 1'b0);
      check_wb("mrd0", 1'b0, 5'd0, 32'd15);
      tick();

      // Flush while idle must block acceptance.
      bus.md_valid = 1'b1;
      bus.md_flush = 1'b1;
      tick();
      bus.md_valid = 1'b0;
      bus.md_flush = 1'b0;
      check_idle("iflush");

      // Flush in the 3rd WAIT cycle together with RDY.
      bus.md_valid = 1'b1;
      bus.md_is_div = 1'b0;
      bus.md_rd    = 5'd7;
      tick();
      bus.md_valid = 1'b0;
      tick();
      tick();
      tick();
      bus.md_flush       = 1'b1;
      bus.data_resultRDY = 1'b1;
      bus.data_result    = 32'd99;
      tick();
      bus.md_flush       = 1'b0;
      bus.data_resultRDY = 1'b0;
      check_idle("flush");
      run_op("after", 1'b1, 32'd20, 32'd4, 5'd12, 0, 32'd5, 1'b0);
      check_wb("after", 1'b1, 5'd12, 32'd5);
      tick();

      // Stale RDY during ISSUE is ignored.
      bus.md_valid  = 1'b1;
      bus.md_is_div = 1'b0;
      bus.md_rd     = 5'd17;
      tick();
      bus.md_valid       = 1'b0;
      bus.data_resultRDY = 1'b1;
      bus.data_result    = 32'd55;
      tick();
      bus.data_resultRDY = 1'b0;
      check("stale.wait", 32'({bus.md_busy, bus.wb_valid}), 32'b10);
      tick();
      check("stale.wait2", 32'({bus.md_busy, bus.wb_valid}), 32'b10);
      bus.data_resultRDY = 1'b1;
      bus.data_result    = 32'd77;
      tick();
      bus.data_resultRDY = 1'b0;
      check_wb("stale", 1'b1, 5'd17, 32'd77);
      tick();

      // Reset mid-WAIT clears everything immediately.
      bus.md_valid = 1'b1;
      bus.md_opA   = 32'hABCD;
      bus.md_rd    = 5'd4;
      tick();
      bus.md_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_idle("mrst");
      check("mrst.opA", bus.md_operandA, 32'd0);
      check("mrst.ctrl", 32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
      tick();
      rst = 1'b0;
      tick();

`ifdef MD_WATCHDOG_EN
      bus.md_valid  = 1'b1;
      bus.md_is_div = 1'b1;
      bus.md_rd     = 5'd6;
      tick();
      bus.md_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("wd.wait8", 32'({bus.md_busy, bus.wb_valid}), 32'b10);
      tick();
      check("wd.tmo", 32'(bus.md_timeout), 32'd1);
      check("wd.wbv", 32'(bus.wb_valid), 32'd1);
      check("wd.reg", 32'(bus.wb_reg), 32'd30);
      check("wd.data", bus.wb_data, 32'd5);
      bus.data_resultRDY = 1'b1;
      tick();
      tick();
      bus.data_resultRDY = 1'b0;
      check_idle("wd.late");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Issue/writeback controller sitting between the decode/execute stage and the multdiv unit. It accepts one MULT/DIV op at a time and latches its operands and destination register. It pulses ctrl_MULT/ctrl_DIV, stalls the pipeline until data_resultRDY, then produces a single-cycle register-file writeback. Exceptions (overflow, divide-by-zero) are redirected to the status register with an op-specific code.

Parameters:
MAX_WAIT, 64, watchdog limit in WAIT cycles (used only with the optional feature)
RSTATUS_REG, 30, register index written on exception
MULT_EXC_CODE, 4, wb_data value on a mult exception
DIV_EXC_CODE, 5, wb_data value on a div exception

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
md_valid  in  1  upstream presents an op
md_is_div  in  1  1=DIV, 0=MULT
md_opA  in  32  operand A
md_opB  in  32  operand B
md_rd  in  5  destination register
md_flush  in  1  kill an in-flight op
md_ready  out  1  controller can accept (state==IDLE)
md_busy  out  1  pipeline stall (state!=IDLE)
ctrl_MULT  out  1  one-cycle start pulse to multdiv
ctrl_DIV  out  1  one-cycle start pulse to multdiv
md_operandA  out  32  latched operand A to multdiv
md_operandB  out  32  latched operand B to multdiv
data_result  in  32  multdiv result
data_exception  in  1  multdiv exception flag
data_resultRDY  in  1  multdiv done
wb_valid  out  1  writeback strobe, one cycle
wb_reg  out  5  writeback register index
wb_data  out  32  writeback data
md_timeout  out  1  watchdog fired; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-high. Reset forces state=IDLE and clears all latches and the wait counter. All outputs reset to 0, except md_ready=1.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - md_ready=1.
  - Accept when md_valid&&md_ready: latch opA, opB, is_div, rd, then go to ISSUE.
  - Upstream holds its inputs while md_valid&&!md_ready.
- ISSUE:
  - Exactly one cycle. ctrl_DIV=is_div and ctrl_MULT=!is_div; never both high.
  - Any data_resultRDY seen in this cycle is ignored as stale.
  - Next state is WAIT, with the counter set to 1.
- WAIT:
  - md_operandA/B stay stable from ISSUE through WB.
  - On data_resultRDY: capture data_result and data_exception into registers, then go to WB.
  - Otherwise increment the counter; it saturates and never wraps.
- WB, exactly one cycle, then IDLE:
  - No exception: wb_reg=rd, wb_data=captured result, wb_valid=(rd!=0).
  - Exception: wb_reg=RSTATUS_REG, wb_data=is_div?DIV_EXC_CODE:MULT_EXC_CODE, wb_valid=1.
- Latency: from accept to wb_valid is N+3 cycles, where N is the number of WAIT cycles before RDY (RDY in the first WAIT cycle gives N=0).
- md_flush:
  - In ISSUE or WAIT: go to IDLE next cycle with no writeback. The multdiv result is discarded, and a later issue restarts the unit.
  - In WB: ignored; the writeback completes.
  - In IDLE: blocks acceptance that cycle.
- Simultaneous events:
  - RDY and flush in the same WAIT cycle: flush wins.
  - reset mid-op: immediate IDLE with no writeback.
- Back-to-back ops: a new op can be accepted in the IDLE cycle following WB. Minimum spacing is 4 cycles.
- Outputs wb_*, ctrl_*, md_busy and md_ready are decoded from state and registers only, with no combinational path from md_valid.

Optional Feature:
Macro MD_WATCHDOG_EN.
- Defined: in WAIT, if the counter reaches MAX_WAIT without RDY, go to WB as an exception. wb_reg=RSTATUS_REG with the op's exception code, and md_timeout=1 for that WB cycle. A late RDY that arrives in IDLE is ignored.
- Undefined: WAIT is unbounded, the counter logic is omitted, and md_timeout is tied to 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ISSUE/WAIT/WB)
  - RSTATUS_REG, MULT_EXC_CODE and DIV_EXC_CODE defaults
  - register-index width constant (5)
- One natural sub-module: md_wait_counter, a saturating counter with clear and enable, instantiated only under MD_WATCHDOG_EN.

Test Plan:
- MULT: accept opA=7, opB=6, rd=3; RDY after 5 WAIT cycles with data_result=42 -> one ctrl_MULT pulse, md_busy high until WB, then wb_valid=1, wb_reg=3, wb_data=42 at accept+8.
- DIV by zero: opB=0, rd=9; RDY with data_exception=1 -> wb_reg=30, wb_data=5, wb_valid=1; ctrl_MULT never asserted.
- MULT overflow with rd=0: data_exception=1 -> wb_reg=30, wb_data=4. Repeat without the exception -> wb_valid stays 0.
- Flush in the 3rd WAIT cycle, with RDY asserted in the same cycle -> no wb_valid; md_ready=1 next cycle; the next op issues normally.
- Stale RDY held high during ISSUE -> ignored; writeback occurs only after RDY is seen in WAIT. Reset asserted mid-WAIT -> all outputs 0 immediately and md_ready=1.
- MD_WATCHDOG_EN with MAX_WAIT=8 and no RDY -> WB at WAIT cycle 8, md_timeout=1, wb_reg=30, wb_data=4 or 5.
